// File: rtl/apb_fabric_master_if.sv
// Bundle of the command/response stream and the APB3 bus around apb_fabric_master.
// The master modport is the initiator's view; the slave modport is the far side (fabric + peripheral).
interface apb_fabric_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Handshakes: a beat transfers on a rising PCLK edge where valid and ready are both
   // high; once raised, valid and its payload stay unchanged until that edge.
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              busy;

   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_fabric_master.sv
// Fabric-side APB3 initiator: one command in flight, SETUP/ACCESS toward the slave,
// registered response beat with read data, slave error and wait-state timeout status.
module apb_fabric_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_fabric_master_if.master bus,
   output logic [1:0]          o_dbg_state
);

   // A zero timeout still needs a 1-bit counter so the vector stays legal.
   localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_cmd_ready, w_cmd_ready_nxt;
   logic              r_psel, w_psel_nxt;
   logic              r_penable, w_penable_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_pwrite, w_pwrite_nxt;
   logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
   logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic              r_rsp_err, w_rsp_err_nxt;
   logic              r_rsp_timeout, w_rsp_timeout_nxt;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_cmd_ready   <= 1'b1;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_busy        <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_cmd_ready   <= w_cmd_ready_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_busy        <= w_busy_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_pwrite_nxt      = r_pwrite;
      w_paddr_nxt       = r_paddr;
      w_pwdata_nxt      = r_pwdata;
      w_rsp_rdata_nxt   = r_rsp_rdata;
      w_rsp_err_nxt     = r_rsp_err;
      w_rsp_timeout_nxt = r_rsp_timeout;

      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               w_state_nxt  = S_SETUP;
               w_pwrite_nxt = bus.cmd_write;
               w_paddr_nxt  = bus.cmd_addr;
               w_pwdata_nxt = bus.cmd_wdata;
            end
         end
         S_SETUP: w_state_nxt = S_ACCESS;
         S_ACCESS: begin
            // A PREADY arriving in the expiry cycle is checked first, so it still completes normally.
            if (bus.PREADY) begin
               w_state_nxt       = S_RESP;
               w_rsp_rdata_nxt   = r_pwrite ? '0 : bus.PRDATA;
               w_rsp_err_nxt     = bus.PSLVERR;
               w_rsp_timeout_nxt = 1'b0;
            end else begin
               if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
               if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
                  w_state_nxt       = S_RESP;
                  w_rsp_rdata_nxt   = '0;
                  w_rsp_err_nxt     = 1'b1;
                  w_rsp_timeout_nxt = 1'b1;
               end
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Every status output is a flop loaded from the decoded next state.
      w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
      w_busy_nxt      = (w_state_nxt != S_IDLE);
      w_psel_nxt      = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      w_penable_nxt   = (w_state_nxt == S_ACCESS);
      w_rsp_valid_nxt = (w_state_nxt == S_RESP);
   end

   assign bus.cmd_ready   = r_cmd_ready;
   assign bus.busy        = r_busy;
   assign bus.PSEL        = r_psel;
   assign bus.PENABLE     = r_penable;
   assign bus.PWRITE      = r_pwrite;
   assign bus.PADDR       = r_paddr;
   assign bus.PWDATA      = r_pwdata;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.rsp_timeout = r_rsp_timeout;
   assign o_dbg_state     = r_state;

endmodule
